// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq : sequential, handshaked ALU.
//   One operation is accepted on the input valid/ready channel. Most ops
//   complete on the accept edge. MUL runs an iterative shift-add over NB_DATA
//   cycles. The registered result and flags are held on the output
//   valid/ready channel until the sink consumes them.
//
// Ports
//   i_clock    : clock, all state on rising edge
//   i_reset    : asynchronous, active-high reset
//   i_valid    : request valid            o_ready    : accepting (IDLE only)
//   i_data_a   : operand A                i_data_b   : operand B / shift amount
//   i_op_code  : operation select
//   o_valid    : result valid             i_ready    : sink accepts result
//   o_result   : result                   o_zero     : result == 0
//   o_carry    : carry / no-borrow / unsigned product overflow
//   o_overflow : signed overflow (ADD/SUB)
//   o_illegal  : opcode not supported
// ----------------------------------------------------------------------------
module alu_seq #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP_CODE = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [NB_DATA-1:0]    i_data_a,
    input  logic [NB_DATA-1:0]    i_data_b,
    input  logic [NB_OP_CODE-1:0] i_op_code,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NB_DATA-1:0]    o_result,
    output logic                  o_zero,
    output logic                  o_carry,
    output logic                  o_overflow,
    output logic                  o_illegal
);
    localparam int NB_SH = $clog2(NB_DATA);

    localparam logic [NB_OP_CODE-1:0] OP_ADD  = NB_OP_CODE'(6'b100000);
    localparam logic [NB_OP_CODE-1:0] OP_SUB  = NB_OP_CODE'(6'b100010);
    localparam logic [NB_OP_CODE-1:0] OP_AND  = NB_OP_CODE'(6'b100100);
    localparam logic [NB_OP_CODE-1:0] OP_OR   = NB_OP_CODE'(6'b100101);
    localparam logic [NB_OP_CODE-1:0] OP_XOR  = NB_OP_CODE'(6'b100110);
    localparam logic [NB_OP_CODE-1:0] OP_NOR  = NB_OP_CODE'(6'b100111);
    localparam logic [NB_OP_CODE-1:0] OP_SRA  = NB_OP_CODE'(6'b000011);
    localparam logic [NB_OP_CODE-1:0] OP_SRL  = NB_OP_CODE'(6'b000010);
    localparam logic [NB_OP_CODE-1:0] OP_SLL  = NB_OP_CODE'(6'b000000);
    localparam logic [NB_OP_CODE-1:0] OP_SLT  = NB_OP_CODE'(6'b101010);
    localparam logic [NB_OP_CODE-1:0] OP_SLTU = NB_OP_CODE'(6'b101011);
    localparam logic [NB_OP_CODE-1:0] OP_MUL  = NB_OP_CODE'(6'b011000);

    localparam logic [NB_SH-1:0] CNT_LAST = NB_SH'(NB_DATA - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [NB_DATA-1:0]     result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   carry_q, carry_d;
    logic                   ovf_q, ovf_d;
    logic                   illegal_q, illegal_d;
    logic                   valid_q, valid_d;
    logic [2*NB_DATA-1:0]   acc_q, acc_d;
    logic [2*NB_DATA-1:0]   mcand_q, mcand_d;
    logic [NB_DATA-1:0]     mplier_q, mplier_d;
    logic [NB_SH-1:0]       cnt_q, cnt_d;

    logic                   accept;
    logic                   mul_last;
    logic [2*NB_DATA-1:0]   acc_step;

    // ---------------- single-cycle ALU (operates on live inputs) -----------
    logic [NB_DATA:0]       sum, diff;
    logic [NB_SH-1:0]       shamt;
    logic [NB_DATA-1:0]     alu_res;
    logic                   alu_carry, alu_ovf, alu_ill;
    logic                   sign_a, sign_b;

    always_comb begin
        sum       = {1'b0, i_data_a} + {1'b0, i_data_b};
        diff      = {1'b0, i_data_a} - {1'b0, i_data_b};
        shamt     = i_data_b[NB_SH-1:0];
        sign_a    = i_data_a[NB_DATA-1];
        sign_b    = i_data_b[NB_DATA-1];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (i_op_code)
            OP_ADD: begin
                alu_res   = sum[NB_DATA-1:0];
                alu_carry = sum[NB_DATA];
                alu_ovf   = (sign_a == sign_b) && (sum[NB_DATA-1] != sign_a);
            end
            OP_SUB: begin
                alu_res   = diff[NB_DATA-1:0];
                alu_carry = ~diff[NB_DATA];   // no-borrow: A >= B unsigned
                alu_ovf   = (sign_a != sign_b) && (diff[NB_DATA-1] != sign_a);
            end
            OP_AND:  alu_res = i_data_a & i_data_b;
            OP_OR:   alu_res = i_data_a | i_data_b;
            OP_XOR:  alu_res = i_data_a ^ i_data_b;
            OP_NOR:  alu_res = ~(i_data_a | i_data_b);
            OP_SRA:  alu_res = $unsigned($signed(i_data_a) >>> shamt);
            OP_SRL:  alu_res = i_data_a >> shamt;
            OP_SLL:  alu_res = i_data_a << shamt;
            OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
            OP_SLTU: alu_res = {{(NB_DATA-1){1'b0}}, (i_data_a < i_data_b)};
            OP_MUL:  alu_res = '0;            // handled by the iterative path
            default: alu_ill = 1'b1;
        endcase
    end

    // ---------------- FSM: state register ----------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state --------------------------------------
    assign accept   = i_valid & o_ready;
    assign mul_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (i_op_code == OP_MUL) ? S_MUL : S_DONE;
            S_MUL:  if (mul_last) state_d = S_DONE;
            S_DONE: if (i_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs -----------------------------------------
    always_comb begin
        o_ready = (state_q == S_IDLE) & ~i_reset;
    end

    assign o_valid    = valid_q;
    assign o_result   = result_q;
    assign o_zero     = zero_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;
    assign o_illegal  = illegal_q;

    // ---------------- datapath next-state ----------------------------------
    // One shift-add step: add the multiplicand when the current multiplier
    // LSB is set. The step result feeds both acc and, on the last step, the
    // output registers so the product is visible the cycle after.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        valid_d   = valid_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (i_op_code == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = {{NB_DATA{1'b0}}, i_data_a};
                        mplier_d = i_data_b;
                        cnt_d    = '0;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = ~|alu_res;
                        carry_d   = alu_carry;
                        ovf_d     = alu_ovf;
                        illegal_d = alu_ill;
                        valid_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (mul_last) begin
                    result_d  = acc_step[NB_DATA-1:0];
                    zero_d    = ~|acc_step[NB_DATA-1:0];
                    carry_d   = |acc_step[2*NB_DATA-1:NB_DATA];
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    valid_d   = 1'b1;
                end
            end
            S_DONE: begin
                // result registers hold; only the valid drops on consume
                if (i_ready) valid_d = 1'b0;
            end
            default: valid_d = 1'b0;
        endcase
    end

    // ---------------- datapath registers -----------------------------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq : scoreboard bench for alu_seq (NB_DATA=8, NB_OP_CODE=6).
// Expected results are queued when a request is driven and popped when the
// DUT presents o_valid.
// ----------------------------------------------------------------------------
module tb_alu_seq;
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_NOR  = 6'b100111;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SLTU = 6'b101011;
    localparam logic [5:0] OP_MUL  = 6'b011000;

    typedef struct packed {
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        exp_t       e;
    } vec_t;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b0;
    logic [7:0] i_data_a = '0;
    logic [7:0] i_data_b = '0;
    logic [5:0] i_op_code = '0;
    logic       o_ready, o_valid, o_zero, o_carry, o_overflow, o_illegal;
    logic [7:0] o_result;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_seq #(.NB_DATA(8), .NB_OP_CODE(6)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_op_code(i_op_code),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_zero(o_zero), .o_carry(o_carry),
        .o_overflow(o_overflow), .o_illegal(o_illegal)
    );

    always #5 i_clock = ~i_clock;

    function automatic vec_t mkv(logic [7:0] a, logic [7:0] b, logic [5:0] op,
                                 logic [7:0] res, logic z, logic c, logic v, logic ill);
        vec_t t;
        t.a = a; t.b = b; t.op = op;
        t.e = {res, z, c, v, ill};
        return t;
    endfunction

    // Reference model built from integer arithmetic and bit loops.
    function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic [5:0] op);
        exp_t e;
        int ua, ub, sa, sb2, r;
        logic [7:0] t;
        ua = int'(a); ub = int'(b);
        sa = a[7] ? ua - 256 : ua;
        sb2 = b[7] ? ub - 256 : ub;
        e = '0;
        t = a;
        case (op)
            OP_ADD: begin r = ua + ub; e.res = r[7:0]; e.c = (r > 255);
                          e.v = ((sa + sb2) > 127) || ((sa + sb2) < -128); end
            OP_SUB: begin r = ua - ub; e.res = r[7:0]; e.c = (ua >= ub);
                          e.v = ((sa - sb2) > 127) || ((sa - sb2) < -128); end
            OP_AND:  e.res = a & b;
            OP_OR:   e.res = a | b;
            OP_XOR:  e.res = a ^ b;
            OP_NOR:  e.res = ~(a | b);
            OP_SRA:  begin for (int i = 0; i < int'(b[2:0]); i++) t = {t[7], t[7:1]}; e.res = t; end
            OP_SRL:  begin for (int i = 0; i < int'(b[2:0]); i++) t = {1'b0, t[7:1]}; e.res = t; end
            OP_SLL:  begin for (int i = 0; i < int'(b[2:0]); i++) t = {t[6:0], 1'b0}; e.res = t; end
            OP_SLT:  e.res = (sa < sb2) ? 8'd1 : 8'd0;
            OP_SLTU: e.res = (ua < ub) ? 8'd1 : 8'd0;
            OP_MUL:  begin r = ua * ub; e.res = r[7:0]; e.c = (r > 255); end
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 8'd0);
        return e;
    endfunction

    // Drives one request, waits (bounded) for o_valid, captures outputs and
    // consumes the result. lat counts the accept edge as 1.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                          output exp_t obs, output int lat, output bit rdy_low);
        i_data_a = a; i_data_b = b; i_op_code = op; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        lat = 1; rdy_low = 1'b1;
        while (!o_valid && lat < 40) begin
            if (o_ready) rdy_low = 1'b0;
            @(posedge i_clock); #1;
            lat++;
        end
        obs = {o_result, o_zero, o_carry, o_overflow, o_illegal};
        i_ready = 1'b1;
        @(posedge i_clock); #1;
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_hs: got ready=%b valid=%b want 0/0", o_ready, o_valid);
        end
        n_vec++;
        if ({o_result, o_zero, o_carry, o_overflow, o_illegal} !== 12'h000) begin
            n_err++; $display("FAIL reset_out: got res=%h z%b c%b v%b i%b want all 0",
                              o_result, o_zero, o_carry, o_overflow, o_illegal);
        end
        repeat (2) @(posedge i_clock);
        #1 i_reset = 1'b0;
        #1;
        n_vec++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release: got ready=%b valid=%b want 1/0", o_ready, o_valid);
        end
    endtask

    task automatic test_add();
        vec_t tab[$]; exp_t obs, e; int lat; bit rl;
        tab.push_back(mkv(8'hFF, 8'h01, OP_ADD, 8'h00, 1, 1, 0, 0));
        tab.push_back(mkv(8'h7F, 8'h01, OP_ADD, 8'h80, 0, 0, 1, 0));
        foreach (tab[k]) begin
            sb.push_back(tab[k].e);
            run_op(tab[k].a, tab[k].b, tab[k].op, obs, lat, rl);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL add[%0d]: got %h want %h", k, obs, e); end
            n_vec++;
            if (lat !== 1) begin n_err++; $display("FAIL add_lat[%0d]: got %0d want 1", k, lat); end
        end
    endtask

    task automatic test_sub();
        vec_t tab[$]; exp_t obs, e; int lat; bit rl;
        tab.push_back(mkv(8'h80, 8'h01, OP_SUB, 8'h7F, 0, 1, 1, 0));
        tab.push_back(mkv(8'h01, 8'h02, OP_SUB, 8'hFF, 0, 0, 0, 0));
        foreach (tab[k]) begin
            sb.push_back(tab[k].e);
            run_op(tab[k].a, tab[k].b, tab[k].op, obs, lat, rl);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL sub[%0d]: got %h want %h", k, obs, e); end
        end
    endtask

    task automatic test_mul();
        vec_t tab[$]; exp_t obs, e; int lat; bit rl;
        tab.push_back(mkv(8'd13,  8'd11,  OP_MUL, 8'h8F, 0, 0, 0, 0));
        tab.push_back(mkv(8'h10,  8'h10,  OP_MUL, 8'h00, 1, 1, 0, 0));
        foreach (tab[k]) begin
            sb.push_back(tab[k].e);
            run_op(tab[k].a, tab[k].b, tab[k].op, obs, lat, rl);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL mul[%0d]: got %h want %h", k, obs, e); end
            n_vec++;
            if (lat !== 9) begin n_err++; $display("FAIL mul_lat[%0d]: got %0d want 9", k, lat); end
            n_vec++;
            if (rl !== 1'b1) begin n_err++; $display("FAIL mul_ready[%0d]: o_ready seen high during MUL", k); end
        end
    endtask

    task automatic test_shift_cmp();
        vec_t tab[$]; exp_t obs, e; int lat; bit rl;
        tab.push_back(mkv(8'h90, 8'h0A, OP_SRA,  8'hE4, 0, 0, 0, 0));
        tab.push_back(mkv(8'h90, 8'h0A, OP_SRL,  8'h24, 0, 0, 0, 0));
        tab.push_back(mkv(8'h81, 8'h01, OP_SLL,  8'h02, 0, 0, 0, 0));
        tab.push_back(mkv(8'hFF, 8'h01, OP_SLT,  8'h01, 0, 0, 0, 0));
        tab.push_back(mkv(8'hFF, 8'h01, OP_SLTU, 8'h00, 1, 0, 0, 0));
        foreach (tab[k]) begin
            sb.push_back(tab[k].e);
            run_op(tab[k].a, tab[k].b, tab[k].op, obs, lat, rl);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e) begin n_err++; $display("FAIL shcmp[%0d]: op=%b got %h want %h", k, tab[k].op, obs, e); end
        end
    endtask

    task automatic test_backpressure();
        exp_t held, e; int lat;
        sb.push_back({8'h46, 1'b0, 1'b0, 1'b0, 1'b0});
        i_data_a = 8'h12; i_data_b = 8'h34; i_op_code = OP_ADD; i_valid = 1'b1;
        @(posedge i_clock); #1;
        lat = 1;
        while (!o_valid && lat < 40) begin @(posedge i_clock); #1; lat++; end
        held = {o_result, o_zero, o_carry, o_overflow, o_illegal};
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1; i_data_a = 8'($urandom); i_data_b = 8'($urandom);
            i_op_code = (c == 2) ? OP_MUL : OP_SUB;
            @(posedge i_clock); #1;
            n_vec++;
            if ({o_result, o_zero, o_carry, o_overflow, o_illegal} !== held || o_valid !== 1'b1
                || o_ready !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d]: got %h v=%b r=%b want %h v=1 r=0", c,
                                  {o_result, o_zero, o_carry, o_overflow, o_illegal}, o_valid, o_ready, held);
            end
        end
        i_ready = 1'b1;
        @(posedge i_clock); #1;
        i_ready = 1'b0; i_valid = 1'b0;
        n_vec++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", o_valid, o_ready);
        end
        e = sb.pop_front();
        n_vec++;
        if (held !== e) begin n_err++; $display("FAIL bp_result: got %h want %h", held, e); end
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        i_data_a = 8'd200; i_data_b = 8'd7; i_op_code = OP_MUL; i_valid = 1'b1;
        @(posedge i_clock); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b1;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_mul_assert: got valid=%b ready=%b want 0/0", o_valid, o_ready);
        end
        @(posedge i_clock); #1;
        i_reset = 1'b0;
        #1;
        n_vec++;
        if (o_ready !== 1'b1 || {o_valid, o_result, o_zero, o_carry, o_overflow, o_illegal} !== 13'h0) begin
            n_err++; $display("FAIL rst_mul_release: got ready=%b valid=%b res=%h z%b c%b v%b i%b want 1 and all 0",
                              o_ready, o_valid, o_result, o_zero, o_carry, o_overflow, o_illegal);
        end
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge i_clock); #1;
            if (o_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mul_stale: got o_valid=1 after reset want 0"); end
    endtask

    task automatic test_illegal();
        vec_t tab[$]; exp_t obs, e; int lat; bit rl;
        tab.push_back(mkv(8'h5A, 8'h33, 6'b111111, 8'h00, 1, 0, 0, 1));
        tab.push_back(mkv(8'hFF, 8'hFF, 6'b000001, 8'h00, 1, 0, 0, 1));
        foreach (tab[k]) begin
            sb.push_back(tab[k].e);
            run_op(tab[k].a, tab[k].b, tab[k].op, obs, lat, rl);
            e = sb.pop_front();
            n_vec++;
            if (obs !== e || lat !== 1) begin
                n_err++; $display("FAIL illegal[%0d]: got %h lat %0d want %h lat 1", k, obs, lat, e);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [12] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
                                 OP_SRA, OP_SRL, OP_SLL, OP_SLT, OP_SLTU, OP_MUL};
        logic [7:0] a, b; logic [5:0] op; exp_t obs, e; int lat, want_lat; bit rl;
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom); b = 8'($urandom);
            op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
            sb.push_back(model(a, b, op));
            run_op(a, b, op, obs, lat, rl);
            want_lat = (op == OP_MUL) ? 9 : 1;
            e = sb.pop_front();
            n_vec++;
            if (obs !== e || lat !== want_lat) begin
                n_err++; $display("FAIL rand[%0d]: a=%h b=%h op=%b got %h lat %0d want %h lat %0d",
                                  n, a, b, op, obs, lat, e, want_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_shift_cmp();
        test_backpressure();
        test_reset_mid_mul();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequential, handshaked, width-parametrised successor to the combinational ALU.
- Accepts one operation through a valid/ready input channel and computes it.
- Single-cycle ops take 1 cycle; multiply is iterative shift-add over NB_DATA cycles.
- Holds the registered result and flags on a valid/ready output channel until consumed. Sits between the operand/opcode source and the result sink in the datapath.

Parameters:
NB_DATA, 8, operand/result width in bits (>=4, power of 2)
NB_OP_CODE, 6, opcode width in bits

Ports:
i_clock  in  1  clock, all state on rising edge
i_reset  in  1  asynchronous, active-high reset
i_valid  in  1  operation request valid
o_ready  out  1  block can accept a request (=1 only in IDLE)
i_data_a  in  NB_DATA  operand A
i_data_b  in  NB_DATA  operand B / shift amount
i_op_code  in  NB_OP_CODE  operation select
o_valid  out  1  result valid
i_ready  in  1  sink accepts result
o_result  out  NB_DATA  result
o_zero  out  1  result == 0
o_carry  out  1  carry/no-borrow/product-overflow
o_overflow  out  1  signed overflow (ADD/SUB only)
o_illegal  out  1  opcode not supported

Behaviour:
- Opcodes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111.
  - SRA 000011, SRL 000010, SLL 000000.
  - SLT 101010, SLTU 101011, MUL 011000.
- Shift amount is i_data_b[$clog2(NB_DATA)-1:0]; upper bits of B are ignored for shifts.
- Reset (async assert, sync release):
  - state=IDLE.
  - o_valid, o_result, o_zero, o_carry, o_overflow, o_illegal all 0.
  - Operand/count registers 0.
  - o_ready = (state==IDLE) & ~i_reset, so o_ready is 0 while reset is asserted.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - Transfer occurs when i_valid & o_ready at a rising edge; A, B and opcode are latched.
  - Non-MUL op: result and flags registered on the same edge, next state DONE. o_valid=1 the following cycle (latency 1).
  - MUL: acc=0, mcand=A (zero-extended to 2*NB_DATA), mplier=B, cnt=0; next state MUL.
- MUL:
  - Each cycle: if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
  - When cnt reaches NB_DATA-1, the last step is performed and the state moves to DONE. o_valid asserts NB_DATA+1 cycles after the accept edge (9 for NB_DATA=8).
  - o_result = acc[NB_DATA-1:0]; o_carry = |acc[2*NB_DATA-1:NB_DATA] (unsigned product overflow); o_overflow=0.
- DONE:
  - o_valid=1; o_ready=0.
  - All outputs hold stable while i_ready=0.
  - On o_valid & i_ready: o_valid drops next cycle and the state returns to IDLE. Result outputs keep their last value.
  - Throughput is 1 op per 2 cycles minimum; i_valid in DONE/MUL is ignored (no transfer).
- Arithmetic:
  - ADD/SUB computed on NB_DATA+1 bits with zero-extended operands.
  - ADD: o_carry = bit NB_DATA.
  - SUB: o_carry = ~bit NB_DATA (no-borrow, i.e. A>=B unsigned).
  - o_overflow (two's complement):
    - ADD: sign(A)==sign(B) and sign(R)!=sign(A).
    - SUB: sign(A)!=sign(B) and sign(R)!=sign(A).
  - Logic/shift/compare ops: o_carry=0, o_overflow=0.
  - SLT/SLTU: result = {0..0, (A<B)}, signed/unsigned compare respectively.
  - SRA: arithmetic right shift; SRL/SLL: zero fill.
- o_zero = ~|o_result for every op, including MUL and illegal.
- Illegal opcode:
  - Takes the single-cycle path: result=0, o_zero=1, o_carry=0, o_overflow=0, o_illegal=1.
  - o_illegal=0 for every legal op.
- Reset mid-operation (MUL or DONE):
  - Immediately IDLE, o_valid=0; the pending result is discarded.
  - The next request after release behaves normally.

Test Plan:
1. NB_DATA=8, ADD A=0xFF B=0x01 -> o_valid one cycle after accept; result 0x00, zero=1, carry=1, overflow=0. Then ADD 0x7F+0x01 -> 0x80, carry=0, overflow=1.
2. SUB A=0x80 B=0x01 -> 0x7F, carry=1, overflow=1. SUB A=0x01 B=0x02 -> 0xFF, carry=0, overflow=0.
3. MUL A=13 B=11 -> o_valid exactly 9 cycles after accept, o_ready=0 throughout; result 0x8F, carry=0. MUL 0x10*0x10 -> result 0x00, zero=1, carry=1.
4. SRA A=0x90 B=0x0A -> 0xE4. SRL same operands -> 0x24. SLL A=0x81 B=0x01 -> 0x02. SLT A=0xFF B=0x01 -> 0x01; SLTU same operands -> 0x00.
5. Backpressure: i_ready=0 for 5 cycles in DONE with i_valid=1 and new operands driven -> outputs unchanged, o_ready=0, no transfer. Raise i_ready -> o_valid low next cycle, o_ready=1.
6. Reset at cycle 4 of a MUL -> o_valid stays 0, o_ready=1 after release, all outputs 0. Then opcode 6'b111111 -> result 0, zero=1, o_illegal=1. Then a random 1000-op self-checking sweep over all opcodes passes.
